stove_heater_scheduler: RTL

Time-slot scheduler that shares the stove's limited heating supply between the cooking surfaces. It sits downstream of the `stove` controller and takes each surface's current power level (0–9). It converts each level into a number of heater-on slots per 9-slot period, and never lets more than `MAX_ACTIVE` heaters conduct in the same slot. When demand exceeds capacity it flags an overload and drops the unmet slots.

---
 rtl/stove_heater_scheduler.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/stove_heater_scheduler.sv
// stove_heater_scheduler
// Shares a limited heating supply between cooking surfaces. Each surface's
// power level (0..9) becomes a number of heater-on slots in a 9-slot period.
// No more than MAX_ACTIVE heaters conduct in any one slot.
// Demand left unserved at the end of a period is dropped, and this raises a
// one-cycle overload pulse.
//
// Build option: define STOVE_SCHED_ROUND_ROBIN_EN to rotate arbitration
// priority with a round-robin pointer. Left undefined, the arbiter uses
// fixed priority, with surface 0 highest.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | stove off; outputs, credits, pointer and counters cleared
// ST_RUN   | slot timer running, heaters scheduled at each boundary

module stove_heater_scheduler #(
   parameter int SURFACES   = 4,
   parameter int MAX_ACTIVE = 2,
   parameter int TICK_DIV   = 50000
) (
   input  logic                  clk,
   input  logic                  async_reset,
   input  logic                  enable,
   input  logic [4*SURFACES-1:0] power_levels,
   output logic [SURFACES-1:0]   heater_on,
   output logic [3:0]            slot_index,
   output logic                  period_start,
   output logic                  overload
);

   localparam int CNT_W = $clog2(TICK_DIV);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                     state_q;
   state_t                     state_d;
   logic                       boundary;

   // Slot timer counts down; a boundary is the edge where it sits at zero.
   logic [CNT_W-1:0]           tick_q;
   logic [3:0]                 next_slot_q;
   logic                       first_slot;

   logic [SURFACES-1:0][3:0]   credit_q;
   logic [SURFACES-1:0][3:0]   credit_d;
   logic [SURFACES-1:0][3:0]   lvl;
   logic                       any_credit;

   logic [SURFACES-1:0]        req;
   logic [SURFACES-1:0]        grant;
   int                         n_granted;
   int                         scan_idx;

`ifdef STOVE_SCHED_ROUND_ROBIN_EN
   localparam int PTR_W = (SURFACES > 1) ? $clog2(SURFACES) : 1;
   logic [PTR_W-1:0]           rr_ptr_q;
   logic [PTR_W-1:0]           rr_ptr_d;
   int                         last_idx;
`endif

   assign first_slot = (next_slot_q == 4'd0);
   assign any_credit = |credit_q;

   // FSM state register; reset takes priority over everything.
   always_ff @(posedge clk) begin
      if (async_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode and boundary detection.
   always_comb begin
      state_d  = state_q;
      boundary = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!enable) begin
               state_d = ST_IDLE;
            end else begin
               boundary = (tick_q == '0);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Clamp levels to 9 and build this slot's request vector.
   // Slot 0 reads the live levels; every later slot runs off the credits
   // snapshotted at slot 0.
   always_comb begin
      lvl = '0;
      req = '0;
      for (int i = 0; i < SURFACES; i++) begin
         lvl[i] = (power_levels[4*i +: 4] > 4'd9) ? 4'd9 : power_levels[4*i +: 4];
         req[i] = first_slot ? (lvl[i] != 4'd0) : (credit_q[i] != 4'd0);
      end
   end

   // Arbiter: scan from the start position (wrapping) and grant the first
   // MAX_ACTIVE requesters.
   always_comb begin
      grant     = '0;
      n_granted = 0;
      scan_idx  = 0;
`ifdef STOVE_SCHED_ROUND_ROBIN_EN
      last_idx  = 0;
`endif
      for (int k = 0; k < SURFACES; k++) begin
`ifdef STOVE_SCHED_ROUND_ROBIN_EN
         scan_idx = int'(rr_ptr_q) + k;
`else
         scan_idx = k;
`endif
         if (scan_idx >= SURFACES) begin
            scan_idx = scan_idx - SURFACES;
         end
         for (int i = 0; i < SURFACES; i++) begin
            if ((i == scan_idx) && req[i] && (n_granted < MAX_ACTIVE)) begin
               grant[i]  = 1'b1;
               n_granted = n_granted + 1;
`ifdef STOVE_SCHED_ROUND_ROBIN_EN
               last_idx  = i;
`endif
            end
         end
      end
   end

   // Credit update: slot 0 reloads from the levels, minus one if granted.
   always_comb begin
      credit_d = credit_q;
      for (int i = 0; i < SURFACES; i++) begin
         credit_d[i] = (first_slot ? lvl[i] : credit_q[i]) - {3'b000, grant[i]};
      end
   end

`ifdef STOVE_SCHED_ROUND_ROBIN_EN
   // The pointer moves to just past the last surface granted, and only when
   // something was granted.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (|grant) begin
         rr_ptr_d = ((last_idx + 1) >= SURFACES) ? '0 : PTR_W'(last_idx + 1);
      end
   end
`endif

   // Datapath registers. Leaving RUN clears everything immediately, so the
   // current slot is abandoned rather than finished.
   always_ff @(posedge clk) begin
      if (async_reset || (state_d == ST_IDLE)) begin
         tick_q       <= '0;
         next_slot_q  <= 4'd0;
         credit_q     <= '0;
         heater_on    <= '0;
         slot_index   <= 4'd0;
         period_start <= 1'b0;
         overload     <= 1'b0;
`ifdef STOVE_SCHED_ROUND_ROBIN_EN
         rr_ptr_q     <= '0;
`endif
      end else begin
         period_start <= 1'b0;
         overload     <= 1'b0;
         if (boundary) begin
            tick_q      <= CNT_W'(TICK_DIV - 1);
            slot_index  <= next_slot_q;
            next_slot_q <= (next_slot_q == 4'd8) ? 4'd0 : next_slot_q + 4'd1;
            heater_on   <= grant;
            credit_q    <= credit_d;
`ifdef STOVE_SCHED_ROUND_ROBIN_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
            if (first_slot) begin
               period_start <= 1'b1;
               overload     <= any_credit;
            end
         end else if (state_q == ST_RUN) begin
            tick_q <= tick_q - 1'b1;
         end
      end
   end

endmodule
